ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipeline control for ID->EX->MEM->WB with hazards and halt FSM.
// In: clk, rst_n, id_* bundle, ex_branch_taken.
// Out: ex_/mem_/wb_* bundles, stall, flush, pc_write, ifid_write, halted, stall_cnt.
module ctrl_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [3:0]  id_opcode,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic [3:0]  id_rd,
  input  logic        id_uses_rt,
  input  logic        id_memRead,
  input  logic        id_memWrite,
  input  logic        id_memToReg,
  input  logic        id_ALUsrc,
  input  logic        id_regWrite,
  input  logic        id_branch,
  input  logic        id_writeFlag,
  input  logic        id_regWriteSelect,
  input  logic        ex_branch_taken,
  output logic        ex_valid,
  output logic        ex_memRead,
  output logic        ex_memWrite,
  output logic        ex_memToReg,
  output logic        ex_ALUsrc,
  output logic        ex_regWrite,
  output logic        ex_branch,
  output logic        ex_writeFlag,
  output logic        ex_regWriteSelect,
  output logic [3:0]  ex_rd,
  output logic        ex_halt,
  output logic        mem_valid,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  output logic        mem_memToReg,
  output logic        mem_ALUsrc,
  output logic        mem_regWrite,
  output logic        mem_branch,
  output logic        mem_writeFlag,
  output logic        mem_regWriteSelect,
  output logic [3:0]  mem_rd,
  output logic        mem_halt,
  output logic        wb_valid,
  output logic        wb_memRead,
  output logic        wb_memWrite,
  output logic        wb_memToReg,
  output logic        wb_ALUsrc,
  output logic        wb_regWrite,
  output logic        wb_branch,
  output logic        wb_writeFlag,
  output logic        wb_regWriteSelect,
  output logic [3:0]  wb_rd,
  output logic        wb_halt,
  output logic        stall,
  output logic        flush,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef struct packed {
    logic       valid;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       ALUsrc;
    logic       regWrite;
    logic       branch;
    logic       writeFlag;
    logic       regWriteSelect;
    logic [3:0] rd;
    logic       halt;
  } ctl_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t state;
  ctl_t   id_b;
  ctl_t   ex_q;
  ctl_t   mem_q;
  ctl_t   wb_q;
  logic   run;
  logic   rd_hit;
  logic   bubble;

  always_comb begin
    id_b                = '0;
    id_b.valid          = id_valid;
    id_b.memRead        = id_memRead;
    id_b.memWrite       = id_memWrite;
    id_b.memToReg       = id_memToReg;
    id_b.ALUsrc         = id_ALUsrc;
    id_b.regWrite       = id_regWrite;
    id_b.branch         = id_branch;
    id_b.writeFlag      = id_writeFlag;
    id_b.regWriteSelect = id_regWriteSelect;
    id_b.rd             = id_rd;
    id_b.halt           = (id_opcode == OP_HLT);
  end

  // r0 is hardwired zero, so a load into it never creates a hazard.
  assign rd_hit = (ex_q.rd != 4'd0) &&
                  ((ex_q.rd == id_rs) ||
                   (id_uses_rt && (ex_q.rd == id_rt)));

  assign run   = (state == RUN);
  assign flush = ex_q.valid & ex_q.branch & ex_branch_taken;
  assign stall = id_valid & ex_q.valid & ex_q.memRead &
                 rd_hit & ~flush;

  assign bubble     = stall | flush | ~id_valid | ~run;
  assign pc_write   = ~stall & run;
  assign ifid_write = ~stall & run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= bubble ? '0 : id_b;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (!bubble && id_b.halt)
            state <= DRAIN;
        end
        DRAIN: begin
          if (wb_q.valid && wb_q.halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          state  <= HALTED;
          halted <= 1'b1;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign ex_valid           = ex_q.valid;
  assign ex_memRead         = ex_q.memRead;
  assign ex_memWrite        = ex_q.memWrite;
  assign ex_memToReg        = ex_q.memToReg;
  assign ex_ALUsrc          = ex_q.ALUsrc;
  assign ex_regWrite        = ex_q.regWrite;
  assign ex_branch          = ex_q.branch;
  assign ex_writeFlag       = ex_q.writeFlag;
  assign ex_regWriteSelect  = ex_q.regWriteSelect;
  assign ex_rd              = ex_q.rd;
  assign ex_halt            = ex_q.halt;

  assign mem_valid          = mem_q.valid;
  assign mem_memRead        = mem_q.memRead;
  assign mem_memWrite       = mem_q.memWrite;
  assign mem_memToReg       = mem_q.memToReg;
  assign mem_ALUsrc         = mem_q.ALUsrc;
  assign mem_regWrite       = mem_q.regWrite;
  assign mem_branch         = mem_q.branch;
  assign mem_writeFlag      = mem_q.writeFlag;
  assign mem_regWriteSelect = mem_q.regWriteSelect;
  assign mem_rd             = mem_q.rd;
  assign mem_halt           = mem_q.halt;

  assign wb_valid           = wb_q.valid;
  assign wb_memRead         = wb_q.memRead;
  assign wb_memWrite        = wb_q.memWrite;
  assign wb_memToReg        = wb_q.memToReg;
  assign wb_ALUsrc          = wb_q.ALUsrc;
  assign wb_regWrite        = wb_q.regWrite;
  assign wb_branch          = wb_q.branch;
  assign wb_writeFlag       = wb_q.writeFlag;
  assign wb_regWriteSelect  = wb_q.regWriteSelect;
  assign wb_rd              = wb_q.rd;
  assign wb_halt            = wb_q.halt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed vector table plus hand sequences for ctrl_pipe.
// Covers hazards, flush priority, halt drain, saturation, async reset.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_opcode, id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic        id_memRead, id_memWrite, id_memToReg, id_ALUsrc;
  logic        id_regWrite, id_branch, id_writeFlag, id_regWriteSelect;
  logic        ex_branch_taken;
  logic        ex_valid, ex_memRead, ex_memWrite, ex_memToReg, ex_ALUsrc;
  logic        ex_regWrite, ex_branch, ex_writeFlag, ex_regWriteSelect;
  logic [3:0]  ex_rd;
  logic        ex_halt;
  logic        mem_valid, mem_memRead, mem_memWrite, mem_memToReg, mem_ALUsrc;
  logic        mem_regWrite, mem_branch, mem_writeFlag, mem_regWriteSelect;
  logic [3:0]  mem_rd;
  logic        mem_halt;
  logic        wb_valid, wb_memRead, wb_memWrite, wb_memToReg, wb_ALUsrc;
  logic        wb_regWrite, wb_branch, wb_writeFlag, wb_regWriteSelect;
  logic [3:0]  wb_rd;
  logic        wb_halt;
  logic        stall, flush, pc_write, ifid_write, halted;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite),
    .id_memToReg(id_memToReg), .id_ALUsrc(id_ALUsrc),
    .id_regWrite(id_regWrite), .id_branch(id_branch),
    .id_writeFlag(id_writeFlag),
    .id_regWriteSelect(id_regWriteSelect),
    .ex_branch_taken(ex_branch_taken),
    .ex_valid(ex_valid), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg),
    .ex_ALUsrc(ex_ALUsrc), .ex_regWrite(ex_regWrite),
    .ex_branch(ex_branch), .ex_writeFlag(ex_writeFlag),
    .ex_regWriteSelect(ex_regWriteSelect), .ex_rd(ex_rd),
    .ex_halt(ex_halt),
    .mem_valid(mem_valid), .mem_memRead(mem_memRead),
    .mem_memWrite(mem_memWrite), .mem_memToReg(mem_memToReg),
    .mem_ALUsrc(mem_ALUsrc), .mem_regWrite(mem_regWrite),
    .mem_branch(mem_branch), .mem_writeFlag(mem_writeFlag),
    .mem_regWriteSelect(mem_regWriteSelect), .mem_rd(mem_rd),
    .mem_halt(mem_halt),
    .wb_valid(wb_valid), .wb_memRead(wb_memRead),
    .wb_memWrite(wb_memWrite), .wb_memToReg(wb_memToReg),
    .wb_ALUsrc(wb_ALUsrc), .wb_regWrite(wb_regWrite),
    .wb_branch(wb_branch), .wb_writeFlag(wb_writeFlag),
    .wb_regWriteSelect(wb_regWriteSelect), .wb_rd(wb_rd),
    .wb_halt(wb_halt),
    .stall(stall), .flush(flush), .pc_write(pc_write),
    .ifid_write(ifid_write), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic       a_mr;
    logic       a_br;
    logic [3:0] a_rd;
    logic       b_v;
    logic [3:0] b_op;
    logic [3:0] b_rs;
    logic [3:0] b_rt;
    logic       b_ut;
    logic       tk;
    logic       e_stall;
    logic       e_flush;
    logic       e_pcw;
    logic       e_nv;
    logic       e_npcw;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] op,
                        input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd, input logic ut,
                        input logic mr, input logic br);
    id_valid          = v;
    id_opcode         = op;
    id_rs             = rs;
    id_rt             = rt;
    id_rd             = rd;
    id_uses_rt        = ut;
    id_memRead        = mr;
    id_memWrite       = 1'b0;
    id_memToReg       = mr;
    id_ALUsrc         = mr;
    id_regWrite       = 1'b1;
    id_branch         = br;
    id_writeFlag      = 1'b0;
    id_regWriteSelect = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ex_branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    //            mr br rd  v op  rs rt ut tk  st fl pw nv npw cnt
    tbl[0]  = '{1, 0, 3,  1, 0,  3, 0, 1, 0,  1, 0, 0, 0, 1, 1};
    tbl[1]  = '{1, 0, 0,  1, 0,  0, 0, 1, 0,  0, 0, 1, 1, 1, 0};
    tbl[2]  = '{1, 0, 5,  1, 0,  1, 5, 1, 0,  1, 0, 0, 0, 1, 1};
    tbl[3]  = '{1, 0, 5,  1, 0,  1, 5, 0, 0,  0, 0, 1, 1, 1, 0};
    tbl[4]  = '{0, 0, 3,  1, 0,  3, 0, 1, 0,  0, 0, 1, 1, 1, 0};
    tbl[5]  = '{0, 1, 0,  1, 0,  2, 4, 1, 1,  0, 1, 1, 0, 1, 0};
    tbl[6]  = '{0, 1, 0,  1, 0,  2, 4, 1, 0,  0, 0, 1, 1, 1, 0};
    tbl[7]  = '{1, 1, 3,  1, 0,  3, 0, 1, 1,  0, 1, 1, 0, 1, 0};
    tbl[8]  = '{1, 0, 3,  0, 0,  3, 0, 1, 0,  0, 0, 1, 0, 1, 0};
    tbl[9]  = '{0, 1, 0,  1, 15, 0, 0, 0, 1,  0, 1, 1, 0, 1, 0};
    tbl[10] = '{0, 0, 1,  1, 15, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0};
    tbl[11] = '{1, 0, 3,  1, 15, 3, 0, 0, 0,  1, 0, 0, 0, 1, 1};

    // reset state, sampled while rst_n is still low
    rst_n = 1'b0;
    ex_branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_pc_write", pc_write, 1);
    chk("rst_ifid_write", ifid_write, 1);
    chk("rst_halted", halted, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_reset();
      set_id(1, 0, 0, 0, tbl[i].a_rd, 0, tbl[i].a_mr, tbl[i].a_br);
      step();
      set_id(tbl[i].b_v, tbl[i].b_op, tbl[i].b_rs, tbl[i].b_rt,
             4'd7, tbl[i].b_ut, 0, 0);
      ex_branch_taken = tbl[i].tk;
      #1;
      chk($sformatf("v%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("v%0d_flush", i), flush, tbl[i].e_flush);
      chk($sformatf("v%0d_pc_write", i), pc_write, tbl[i].e_pcw);
      step();
      chk($sformatf("v%0d_ex_valid", i), ex_valid, tbl[i].e_nv);
      chk($sformatf("v%0d_next_pc_write", i), pc_write, tbl[i].e_npcw);
      chk($sformatf("v%0d_stall_cnt", i), stall_cnt, tbl[i].e_cnt);
    end

    // HLT behind a load-use hazard, then drain to HALTED
    do_reset();
    set_id(1, 0, 0, 0, 3, 0, 1, 0);
    step();
    set_id(1, 15, 3, 0, 0, 0, 0, 0);
    #1;
    chk("hlt_stall", stall, 1);
    step();
    chk("hlt_held_ex_valid", ex_valid, 0);
    chk("hlt_held_pc_write", pc_write, 1);
    step();
    chk("hlt_in_ex", ex_halt, 1);
    chk("hlt_drain_pc_write", pc_write, 0);
    chk("hlt_drain_ifid_write", ifid_write, 0);
    set_id(1, 0, 1, 2, 4, 1, 0, 0);
    step();
    chk("drain_bubble", ex_valid, 0);
    chk("drain_mem_halt", mem_halt, 1);
    chk("drain_halted_c1", halted, 0);
    step();
    chk("drain_wb_halt", wb_halt, 1);
    chk("drain_halted_c2", halted, 0);
    step();
    chk("halted_c3", halted, 1);
    for (int k = 0; k < 3; k++) step();
    chk("halted_held", halted, 1);
    chk("halted_pc_write", pc_write, 0);
    chk("halted_wb_empty", wb_valid, 0);

    // async reset mid-DRAIN
    do_reset();
    set_id(1, 0, 0, 0, 3, 0, 1, 0);
    step();
    set_id(1, 15, 3, 0, 0, 0, 0, 0);
    step();
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("pre_rst_mem_halt", mem_halt, 1);
    chk("pre_rst_stall_cnt", stall_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_valid", mem_valid, 0);
    chk("arst_mem_halt", mem_halt, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_pc_write", pc_write, 1);
    chk("arst_halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    set_id(1, 0, 1, 2, 4, 1, 0, 0);
    #1;
    chk("post_rst_pc_write", pc_write, 1);
    step();
    chk("post_rst_ex_valid", ex_valid, 1);

    // stall counter: alternating stalls, then saturation
    do_reset();
    set_id(1, 0, 3, 0, 3, 0, 1, 0);
    for (int k = 0; k < 20; k++) step();
    chk("cnt_alt_20", stall_cnt, 16'd10);
    force dut.stall_cnt = 16'hFFFD;
    #1;
    release dut.stall_cnt;
    for (int k = 0; k < 10; k++) step();
    chk("cnt_saturate", stall_cnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
